alu_issue: RTL and testbench
============================

# alu_issue

Multi-cycle issue and writeback stage that sits directly upstream of the 8-bit ALU (operands A/B, 3-bit ALUSel, Result, ZFlag). Accepts register-to-register or register-to-immediate commands over a valid/ready handshake. It reads operands from an internal 4x8 register file and drives the ALU inputs from registered outputs. It then captures Result/ZFlag, writes the result back to the register file, and reports completion.

## Interface
- REG_COUNT, 4, number of 8-bit registers; address width fixed at 2 bits
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- CmdValid  in  1  command present
- CmdReady  out  1  stage can accept a command
- CmdOp  in  3  ALU operation code, passed unchanged to ALUSel
- CmdDst, CmdSrcA, CmdSrcB  in  2 each  destination and source register addresses
- CmdImmEn  in  1  1: B operand = CmdImm; 0: B operand = reg[CmdSrcB]
- CmdImm  in  8  immediate operand
- WrEn, WrAddr, WrData  in  1/2/8  external register load port
- RdAddr  in  2  debug read address; RdData  out  8  = reg[RdAddr], combinational
- A, B  out  8 each  registered ALU operands
- ALUSel  out  3  registered ALU operation select
- Result  in  8  ALU result (combinational from A, B, ALUSel)
- ZFlag  in  1  ALU zero flag
- DoneValid  out  1  one-cycle completion pulse
- DoneResult  out  8  last written-back result, held
- ZReg  out  1  zero flag of last completed command, held

## Operation
- States: IDLE, EXEC, WB. Reset state is IDLE.
- IDLE:
  - CmdReady=1.
  - On CmdValid: latch CmdDst; load A=reg[CmdSrcA], B=(CmdImmEn ? CmdImm : reg[CmdSrcB]), ALUSel=CmdOp; go to EXEC.
  - Without CmdValid: A/B/ALUSel hold.
- EXEC:
  - CmdReady=0.
  - Capture Result into an internal result register and ZFlag into a flag register; go to WB.
- WB:
  - CmdReady=0; DoneValid=1.
  - On the exiting edge: reg[dst]=captured result, DoneResult=captured result, ZReg=captured flag; go to IDLE.
- Arithmetic is the ALU's: 8-bit, modulo 256. No carry or overflow is tracked. Codes 001/010/011 all yield A-B.
- Operand read bypass: a WrEn in the same IDLE cycle as command acceptance does not forward. Operands use the pre-write register values.
- External write vs writeback in the same WB edge to the same address: writeback wins and the external write is dropped. For different addresses, both writes occur.
- External writes during EXEC do not affect latched operands.
- rst during any state:
  - Immediate return to IDLE; the in-flight command is discarded with no writeback.
  - All registers, A, B, ALUSel, DoneResult, ZReg, DoneValid and internal captures go to 0.
- Commands presented while rst=1 are ignored.

## Timing
- Reset values: CmdReady=1, DoneValid=0, A=B=0x00, ALUSel=000, DoneResult=0x00, ZReg=0, all registers 0x00, RdData=0x00.
- Command accepted at edge k (CmdValid&&CmdReady):
  - A/B/ALUSel are valid after k.
  - Result/ZFlag are captured at k+1.
  - DoneValid is high between k+1 and k+2.
  - The register file, DoneResult and ZReg update at k+2.
  - CmdReady returns high after k+2.
- Latency is 2 cycles from acceptance to writeback. Throughput is 1 command per 3 cycles.
- CmdValid held high continuously gives acceptances at k, k+3, k+6, ...
- Result must be stable within one cycle of A/B/ALUSel changing.
- DoneValid is never high for more than one consecutive cycle.

## Test plan
- Load R1=0x05, R2=0x03; cmd op=000 dst=0 srcA=1 srcB=2 -> A=0x05, B=0x03 after accept; DoneValid one cycle; DoneResult=0x08, ZReg=0, RdData(0)=0x08.
- R1=0x05, R2=0x05; op=001 dst=3 -> R3=0x00, ZReg=1. Then op=100 with R1, R2 -> 0x05, ZReg=0.
- R1=0xFF; op=000 with immediate 0x01 (CmdImmEn=1) -> 0x00 (wrap), ZReg=1. Then op=111 with R1=0xA5 and immediate 0x0F -> 0xAA.
- CmdValid held high for two commands -> CmdReady low for exactly 2 cycles; second acceptance exactly 3 edges after first; two DoneValid pulses 3 cycles apart.
- During WB for dst=2, external WrEn to addr 2 with 0x77 -> R2 holds the ALU result. Repeat with WrAddr=1 -> both writes land.
- Assert rst for one cycle while in EXEC -> no DoneValid, all registers 0x00, CmdReady=1; the next command executes normally.

Source files
------------

// File: rtl/alu_issue_if.sv
// alu_issue_if: command handshake, register ports, ALU operands/result and completion signals of alu_issue.
interface alu_issue_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src_a;
  logic [1:0] cmd_src_b;
  logic       cmd_imm_en;
  logic [7:0] cmd_imm;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] alu_sel;
  logic [7:0] result;
  logic       zflag;
  logic       done_valid;
  logic [7:0] done_result;
  logic       zreg;
  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm,
    input  wr_en, wr_addr, wr_data, rd_addr, result, zflag,
    output cmd_ready, rd_data, a, b, alu_sel, done_valid, done_result, zreg
  );
  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm,
    output wr_en, wr_addr, wr_data, rd_addr, result, zflag,
    input  cmd_ready, rd_data, a, b, alu_sel, done_valid, done_result, zreg
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: three-state issue/execute/writeback stage feeding an external 8-bit ALU from a 4x8 register file.
module alu_issue #(
  parameter int REG_COUNT = 4
) (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t     state;
  logic [7:0] regs [REG_COUNT];
  logic [1:0] dst;
  logic [7:0] res;
  logic       zf;
  assign bus.rd_data = regs[bus.rd_addr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      dst             <= '0;
      res             <= '0;
      zf              <= 1'b0;
      bus.cmd_ready   <= 1'b1;
      bus.a           <= '0;
      bus.b           <= '0;
      bus.alu_sel     <= '0;
      bus.done_valid  <= 1'b0;
      bus.done_result <= '0;
      bus.zreg        <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      // writeback below is assigned later, so it overrides a same-address external write
      if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          dst           <= bus.cmd_dst;
          bus.a         <= regs[bus.cmd_src_a];
          bus.b         <= bus.cmd_imm_en ? bus.cmd_imm : regs[bus.cmd_src_b];
          bus.alu_sel   <= bus.cmd_op;
          bus.cmd_ready <= 1'b0;
          state         <= EXEC;
        end
        EXEC: begin
          res            <= bus.result;
          zf             <= bus.zflag;
          bus.done_valid <= 1'b1;
          state          <= WB;
        end
        default: begin
          regs[dst]       <= res;
          bus.done_result <= res;
          bus.zreg        <= zf;
          bus.done_valid  <= 1'b0;
          bus.cmd_ready   <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized and directed checks of alu_issue against a register-file model and a behavioural ALU.
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  alu_issue_if bus();
  alu_issue dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
    case (op)
      3'b000:                return 8'(x + y);
      3'b001, 3'b010, 3'b011: return 8'(x - y);
      3'b100:                return x & y;
      3'b101:                return x | y;
      3'b110:                return ~(x | y);
      default:               return x ^ y;
    endcase
  endfunction
  assign bus.result = alu_f(bus.a, bus.b, bus.alu_sel);
  assign bus.zflag  = bus.result == 8'h00;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m [4];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ext_write(input logic [1:0] addr, input logic [7:0] data);
    bus.wr_en = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick;
    bus.wr_en = 1'b0;
    m[addr] = data;
  endtask
  // we[0]/we[1]/we[2]: external write during the accept, EXEC and WB cycles
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic ie, input logic [7:0] imm,
                         input logic [2:0] we, input logic [1:0] wa, input logic [7:0] wd);
    logic [7:0] ea, eb, er;
    ea = m[sa];
    eb = ie ? imm : m[sb];
    er = alu_f(ea, eb, op);
    n_chk++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: got %b want 1", tag, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_dst = dst;
    bus.cmd_src_a = sa;
    bus.cmd_src_b = sb;
    bus.cmd_imm_en = ie;
    bus.cmd_imm = imm;
    bus.wr_en = we[0];
    bus.wr_addr = wa;
    bus.wr_data = wd;
    tick;
    if (we[0]) m[wa] = wd;
    bus.cmd_valid = 1'b0;
    bus.wr_en = we[1];
    n_chk++;
    if ({bus.a, bus.b, bus.alu_sel, bus.cmd_ready, bus.done_valid} !== {ea, eb, op, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s operands: a=%h b=%h sel=%b rdy=%b dv=%b want a=%h b=%h sel=%b rdy=0 dv=0",
               tag, bus.a, bus.b, bus.alu_sel, bus.cmd_ready, bus.done_valid, ea, eb, op);
    end
    tick;
    if (we[1]) m[wa] = wd;
    bus.wr_en = we[2];
    n_chk++;
    if ({bus.done_valid, bus.cmd_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s wb_phase: dv=%b rdy=%b want dv=1 rdy=0", tag, bus.done_valid, bus.cmd_ready);
    end
    tick;
    if (we[2]) m[wa] = wd;
    m[dst] = er;
    bus.wr_en = 1'b0;
    n_chk++;
    if ({bus.done_valid, bus.cmd_ready, bus.done_result, bus.zreg} !== {1'b0, 1'b1, er, er == 8'h00}) begin
      n_fail++;
      $display("FAIL %s done: dv=%b rdy=%b res=%h z=%b want dv=0 rdy=1 res=%h z=%b",
               tag, bus.done_valid, bus.cmd_ready, bus.done_result, bus.zreg, er, er == 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      #1;
      n_chk++;
      if (bus.rd_data !== m[i]) begin
        n_fail++;
        $display("FAIL %s reg%0d: got %h want %h", tag, i, bus.rd_data, m[i]);
      end
    end
  endtask
  task automatic test_reset;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b101;
    bus.cmd_dst = 2'd1;
    bus.cmd_src_a = 2'd2;
    bus.cmd_src_b = 2'd3;
    bus.cmd_imm_en = 1'b1;
    bus.cmd_imm = 8'h5A;
    bus.wr_en = 1'b1;
    bus.wr_addr = 2'd1;
    bus.wr_data = 8'hC3;
    bus.rd_addr = 2'd0;
    rst = 1'b1;
    tick;
    tick;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    for (int pass = 0; pass < 2; pass++) begin
      n_chk++;
      if ({bus.cmd_ready, bus.done_valid, bus.a, bus.b, bus.alu_sel, bus.done_result, bus.zreg} !==
          {1'b1, 1'b0, 8'h00, 8'h00, 3'b000, 8'h00, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_outputs pass%0d: rdy=%b dv=%b a=%h b=%h sel=%b res=%h z=%b want 1 0 00 00 000 00 0",
                 pass, bus.cmd_ready, bus.done_valid, bus.a, bus.b, bus.alu_sel, bus.done_result, bus.zreg);
      end
      for (int i = 0; i < 4; i++) begin
        bus.rd_addr = 2'(i);
        #1;
        n_chk++;
        if (bus.rd_data !== 8'h00) begin
          n_fail++;
          $display("FAIL reset_reg%0d pass%0d: got %h want 00", i, pass, bus.rd_data);
        end
      end
      bus.cmd_valid = 1'b0;
      bus.wr_en = 1'b0;
      rst = 1'b0;
      tick;
    end
  endtask
  task automatic test_directed;
    ext_write(2'd1, 8'h05);
    ext_write(2'd2, 8'h03);
    run_cmd("add", 3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 3'b000, 2'd0, 8'h00);
    ext_write(2'd2, 8'h05);
    run_cmd("sub_zero", 3'b001, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 3'b000, 2'd0, 8'h00);
    run_cmd("op100", 3'b100, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 3'b000, 2'd0, 8'h00);
    ext_write(2'd1, 8'hFF);
    run_cmd("imm_wrap", 3'b000, 2'd0, 2'd1, 2'd2, 1'b1, 8'h01, 3'b000, 2'd0, 8'h00);
    ext_write(2'd1, 8'hA5);
    run_cmd("xor_imm", 3'b111, 2'd0, 2'd1, 2'd2, 1'b1, 8'h0F, 3'b000, 2'd0, 8'h00);
  endtask
  task automatic test_write_races;
    ext_write(2'd0, 8'h21);
    ext_write(2'd1, 8'h10);
    run_cmd("wb_same_addr", 3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 3'b100, 2'd2, 8'h77);
    run_cmd("wb_diff_addr", 3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 3'b100, 2'd1, 8'h77);
    run_cmd("no_bypass", 3'b010, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 3'b001, 2'd0, 8'h99);
    run_cmd("exec_write", 3'b101, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 3'b010, 2'd0, 8'h44);
  endtask
  task automatic test_back_to_back;
    logic [7:0] r1, a2, b2, r2, ga, gb, gd1, gd2;
    logic [6:0] rdy_v, dv_v;
    ext_write(2'd0, 8'h12);
    ext_write(2'd1, 8'h34);
    r1 = alu_f(m[0], m[1], 3'b000);
    a2 = r1;
    b2 = 8'h3C;
    r2 = alu_f(a2, b2, 3'b111);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b000;
    bus.cmd_dst = 2'd1;
    bus.cmd_src_a = 2'd0;
    bus.cmd_src_b = 2'd1;
    bus.cmd_imm_en = 1'b0;
    for (int s = 0; s < 7; s++) begin
      tick;
      rdy_v[s] = bus.cmd_ready;
      dv_v[s] = bus.done_valid;
      if (s == 0) begin
        bus.cmd_op = 3'b111;
        bus.cmd_dst = 2'd2;
        bus.cmd_src_a = 2'd1;
        bus.cmd_imm_en = 1'b1;
        bus.cmd_imm = b2;
      end
      if (s == 2) gd1 = bus.done_result;
      if (s == 3) begin
        ga = bus.a;
        gb = bus.b;
        bus.cmd_valid = 1'b0;
      end
      if (s == 5) gd2 = bus.done_result;
    end
    m[1] = r1;
    m[2] = r2;
    n_chk++;
    if (rdy_v !== 7'b1100100) begin
      n_fail++;
      $display("FAIL b2b_ready_pattern: got %b want 1100100", rdy_v);
    end
    n_chk++;
    if (dv_v !== 7'b0010010) begin
      n_fail++;
      $display("FAIL b2b_done_pattern: got %b want 0010010", dv_v);
    end
    n_chk++;
    if ({ga, gb} !== {a2, b2}) begin
      n_fail++;
      $display("FAIL b2b_second_operands: a=%h b=%h want a=%h b=%h", ga, gb, a2, b2);
    end
    n_chk++;
    if ({gd1, gd2} !== {r1, r2}) begin
      n_fail++;
      $display("FAIL b2b_results: got %h %h want %h %h", gd1, gd2, r1, r2);
    end
  endtask
  task automatic test_reset_exec;
    ext_write(2'd1, 8'h0A);
    ext_write(2'd2, 8'h0B);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b000;
    bus.cmd_dst = 2'd3;
    bus.cmd_src_a = 2'd1;
    bus.cmd_src_b = 2'd2;
    bus.cmd_imm_en = 1'b0;
    tick;
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    for (int s = 0; s < 3; s++) begin
      n_chk++;
      if ({bus.cmd_ready, bus.done_valid, bus.a, bus.b, bus.done_result} !== {1'b1, 1'b0, 8'h00, 8'h00, 8'h00}) begin
        n_fail++;
        $display("FAIL rst_exec cycle%0d: rdy=%b dv=%b a=%h b=%h res=%h want 1 0 00 00 00",
                 s, bus.cmd_ready, bus.done_valid, bus.a, bus.b, bus.done_result);
      end
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr = 2'(i);
      #1;
      n_chk++;
      if (bus.rd_data !== 8'h00) begin
        n_fail++;
        $display("FAIL rst_exec_reg%0d: got %h want 00", i, bus.rd_data);
      end
    end
    ext_write(2'd1, 8'h0A);
    ext_write(2'd2, 8'h0B);
    run_cmd("after_rst", 3'b000, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 3'b000, 2'd0, 8'h00);
  endtask
  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) ext_write(2'($urandom_range(0, 3)), 8'($urandom));
      run_cmd($sformatf("rand%0d", n), 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
              1'($urandom), 8'($urandom), ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom),
              2'($urandom), 8'($urandom));
    end
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_dst = '0;
    bus.cmd_src_a = '0;
    bus.cmd_src_b = '0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm = '0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    test_reset;
    test_directed;
    test_write_races;
    test_back_to_back;
    test_reset_exec;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
